// File: rtl/mscell_harvest.sv
// Metastable-cell entropy harvester: synchronizes and XOR-combines raw cells,
// optionally Von Neumann debiases, packs words and watches for stuck sources.
module mscell_harvest #(
   parameter int N_CELLS   = 4,
   parameter int OUT_W     = 8,
   parameter int REP_LIMIT = 32
) (
   input  logic               clk_sampling,
   input  logic               rst,
   input  logic               en,
   input  logic               debias_en,
   input  logic [N_CELLS-1:0] cell_in,
   output logic [N_CELLS-1:0] cell_en,
   output logic [OUT_W-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               health_fail
);
   localparam int CNT_W = $clog2(OUT_W + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUT_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [7:0]       REP_MAX  = 8'(REP_LIMIT);

   typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, HOLD = 2'd2} state_t;

   logic [N_CELLS-1:0] sync_bits;
   logic               raw_bit;

   generate
      for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_sync
         logic meta_reg;
         logic stable_reg;
         always_ff @(posedge clk_sampling or posedge rst) begin
            if (rst) begin
               meta_reg   <= 1'b0;
               stable_reg <= 1'b0;
            end else begin
               meta_reg   <= cell_in[gi];
               stable_reg <= meta_reg;
            end
         end
         assign sync_bits[gi] = stable_reg;
      end
   endgenerate

   assign raw_bit = ^sync_bits;

   state_t             state_reg, state_next;
   logic               debias_reg, debias_next;
   logic               phase_reg, phase_next;
   logic               first_reg, first_next;
   logic [OUT_W-1:0]   sr_reg, sr_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [OUT_W-1:0]   data_reg, data_next;
   logic               valid_reg, valid_next;
   logic               prev_reg, prev_next;
   logic [7:0]         rep_reg, rep_next;
   logic               health_reg, health_next;
   logic [N_CELLS-1:0] cell_en_reg, cell_en_next;
   logic               handshake;
   logic               bit_ok;
   logic               bit_val;

   always_comb begin
      handshake   = valid_reg & out_ready;
      bit_ok      = 1'b0;
      bit_val     = raw_bit;
      state_next  = state_reg;
      debias_next = (state_reg == IDLE) ? debias_en : debias_reg;
      phase_next  = phase_reg;
      first_next  = first_reg;
      sr_next     = sr_reg;
      cnt_next    = cnt_reg;
      data_next   = data_reg;
      valid_next  = valid_reg & ~handshake;
      prev_next   = prev_reg;
      rep_next    = rep_reg;
      health_next = health_reg;

      // Von Neumann pairing: first half of a pair is parked, second half decides.
      if (state_reg == COLLECT) begin
         if (!debias_reg) begin
            bit_ok = 1'b1;
         end else if (!phase_reg) begin
            phase_next = 1'b1;
            first_next = raw_bit;
         end else begin
            phase_next = 1'b0;
            bit_ok     = first_reg ^ raw_bit;
            bit_val    = first_reg;
         end
      end

      case (state_reg)
         IDLE: begin
            if (en) begin
               state_next = COLLECT;
               phase_next = 1'b0;
            end
         end
         COLLECT: begin
            if (!en) begin
               state_next = IDLE;
               sr_next    = '0;
               cnt_next   = '0;
            end else begin
               if (bit_ok && cnt_reg != CNT_FULL) begin
                  sr_next  = {sr_reg[OUT_W-2:0], bit_val};
                  cnt_next = cnt_reg + CNT_ONE;
               end
               if (cnt_next == CNT_FULL) begin
                  if (!health_reg && (!valid_reg || handshake)) begin
                     data_next  = sr_next;
                     valid_next = 1'b1;
                     cnt_next   = '0;
                  end else if (valid_reg && !handshake) begin
                     state_next = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            if (!en) begin
               state_next = IDLE;
               sr_next    = '0;
               cnt_next   = '0;
            end else if (handshake) begin
               state_next = COLLECT;
               phase_next = 1'b0;
               // A failed source keeps the counter full so nothing more is packed.
               if (!health_reg) begin
                  data_next  = sr_reg;
                  valid_next = 1'b1;
                  sr_next    = '0;
                  cnt_next   = '0;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      if (state_reg == IDLE) begin
         rep_next = '0;
      end else begin
         prev_next = raw_bit;
         if (rep_reg == 8'd0 || raw_bit != prev_reg) begin
            rep_next = 8'd1;
         end else if (rep_reg != 8'hFF) begin
            rep_next = rep_reg + 8'd1;
         end
         if (rep_next >= REP_MAX) begin
            health_next = 1'b1;
         end
      end

      cell_en_next = {N_CELLS{state_next != IDLE}};
   end

   always_ff @(posedge clk_sampling or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         debias_reg  <= 1'b0;
         phase_reg   <= 1'b0;
         first_reg   <= 1'b0;
         sr_reg      <= '0;
         cnt_reg     <= '0;
         data_reg    <= '0;
         valid_reg   <= 1'b0;
         prev_reg    <= 1'b0;
         rep_reg     <= '0;
         health_reg  <= 1'b0;
         cell_en_reg <= '0;
      end else begin
         state_reg   <= state_next;
         debias_reg  <= debias_next;
         phase_reg   <= phase_next;
         first_reg   <= first_next;
         sr_reg      <= sr_next;
         cnt_reg     <= cnt_next;
         data_reg    <= data_next;
         valid_reg   <= valid_next;
         prev_reg    <= prev_next;
         rep_reg     <= rep_next;
         health_reg  <= health_next;
         cell_en_reg <= cell_en_next;
      end
   end

   assign cell_en     = cell_en_reg;
   assign out_data    = data_reg;
   assign out_valid   = valid_reg;
   assign health_fail = health_reg;

endmodule
